vga_config: RTL and testbench

- Configuration register block for the VGA controller.
- Accepts single-cycle register writes over a Valid/Addr/Data bus and selects one of three standard 60 Hz video modes.
- Presents the selected mode's porch, sync-pulse and counter-maximum values as registered outputs to the H/V timing generator.
- Signals each accepted write with a one-cycle Load_config pulse.

---
 rtl/vga_cfg_pkg.sv | 40 ++++
 rtl/vga_mode_rom.sv | 34 +++
 rtl/vga_config.sv | 73 +++++++
 tb/tb_vga_config.sv | 136 +++++++++++++
 4 files changed

// File: rtl/vga_cfg_pkg.sv
// Shared constants, mode codes and timing bundle for the VGA configuration block.
package vga_cfg_pkg;

   localparam int CONFIG_WIDTH  = 2;
   localparam int PORCH_WIDTH   = 8;
   localparam int REZ_MAX_WIDTH = 11;
   localparam int PULSE_WIDTH   = 8;

   localparam logic [CONFIG_WIDTH-1:0] MODE_ADDR     = 2'b10;
   localparam logic [CONFIG_WIDTH-1:0] MODE_640x480  = 2'b00;
   localparam logic [CONFIG_WIDTH-1:0] MODE_800x600  = 2'b01;
   localparam logic [CONFIG_WIDTH-1:0] MODE_1024x768 = 2'b10;

   typedef struct packed {
      logic [PORCH_WIDTH-1:0]   h_front_porch;
      logic [PORCH_WIDTH-1:0]   h_back_porch;
      logic [PULSE_WIDTH-1:0]   h_sync_pulse;
      logic [REZ_MAX_WIDTH-1:0] h_count_max;
      logic [PORCH_WIDTH-1:0]   v_front_porch;
      logic [PORCH_WIDTH-1:0]   v_back_porch;
      logic [PULSE_WIDTH-1:0]   v_sync_pulse;
      logic [REZ_MAX_WIDTH-1:0] v_count_max;
   } vga_timing_t;

   localparam vga_timing_t TIMING_640x480 = '{
      h_front_porch: 8'd16,  h_back_porch: 8'd48,  h_sync_pulse: 8'd96,  h_count_max: 11'd799,
      v_front_porch: 8'd10,  v_back_porch: 8'd33,  v_sync_pulse: 8'd2,   v_count_max: 11'd524
   };

   localparam vga_timing_t TIMING_800x600 = '{
      h_front_porch: 8'd40,  h_back_porch: 8'd88,  h_sync_pulse: 8'd128, h_count_max: 11'd1055,
      v_front_porch: 8'd1,   v_back_porch: 8'd23,  v_sync_pulse: 8'd4,   v_count_max: 11'd627
   };

   localparam vga_timing_t TIMING_1024x768 = '{
      h_front_porch: 8'd24,  h_back_porch: 8'd160, h_sync_pulse: 8'd136, h_count_max: 11'd1343,
      v_front_porch: 8'd3,   v_back_porch: 8'd29,  v_sync_pulse: 8'd6,   v_count_max: 11'd805
   };

endpackage

// File: rtl/vga_mode_rom.sv
// Combinational lookup from a mode code to its timing bundle; code 2'b11 is reserved.
module vga_mode_rom
   import vga_cfg_pkg::*;
(
   input  logic [CONFIG_WIDTH-1:0] mode,
   output vga_timing_t             timing,
   output logic                    legal
);

   // Mode code to timing table; reserved code reports not-legal.
   always_comb begin
      timing = TIMING_640x480;
      legal  = 1'b0;
      case (mode)
         MODE_640x480: begin
            timing = TIMING_640x480;
            legal  = 1'b1;
         end
         MODE_800x600: begin
            timing = TIMING_800x600;
            legal  = 1'b1;
         end
         MODE_1024x768: begin
            timing = TIMING_1024x768;
            legal  = 1'b1;
         end
         default: begin
            timing = TIMING_640x480;
            legal  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/vga_config.sv
// VGA configuration register: decodes mode writes and holds the selected timing in flops.
module vga_config
   import vga_cfg_pkg::*;
(
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     Valid,
   input  logic [CONFIG_WIDTH-1:0]  Addr,
   input  logic [CONFIG_WIDTH-1:0]  Data,
   output logic                     Load_config,
   output logic [PORCH_WIDTH-1:0]   H_front_porch,
   output logic [PORCH_WIDTH-1:0]   H_back_porch,
   output logic [PORCH_WIDTH-1:0]   V_front_porch,
   output logic [PORCH_WIDTH-1:0]   V_back_porch,
   output logic [REZ_MAX_WIDTH-1:0] H_count_max,
   output logic [PULSE_WIDTH-1:0]   H_sync_pulse,
   output logic [REZ_MAX_WIDTH-1:0] V_count_max,
   output logic [PULSE_WIDTH-1:0]   V_sync_pulse
);

   vga_timing_t rom_timing;
   logic        rom_legal;
   logic        accept;
   vga_timing_t timing_d, timing_q;
   logic        load_d, load_q;

   vga_mode_rom u_rom (
      .mode   (Data),
      .timing (rom_timing),
      .legal  (rom_legal)
   );

   // Write decode: only a legal mode code at MODE_ADDR is taken.
   always_comb begin
      accept   = 1'b0;
      timing_d = timing_q;
      load_d   = 1'b0;
      if ((Valid == 1'b1) && (Addr == MODE_ADDR) && (rom_legal == 1'b1)) begin
         accept = 1'b1;
      end else begin
         accept = 1'b0;
      end
      if (accept == 1'b1) begin
         timing_d = rom_timing;
         load_d   = 1'b1;
      end else begin
         timing_d = timing_q;
         load_d   = 1'b0;
      end
   end

   // Output registers; reset wins over a simultaneous write.
   always_ff @(posedge Clk) begin
      if (Rst == 1'b0) begin
         timing_q <= TIMING_640x480;
         load_q   <= 1'b0;
      end else begin
         timing_q <= timing_d;
         load_q   <= load_d;
      end
   end

   assign Load_config   = load_q;
   assign H_front_porch = timing_q.h_front_porch;
   assign H_back_porch  = timing_q.h_back_porch;
   assign H_sync_pulse  = timing_q.h_sync_pulse;
   assign H_count_max   = timing_q.h_count_max;
   assign V_front_porch = timing_q.v_front_porch;
   assign V_back_porch  = timing_q.v_back_porch;
   assign V_sync_pulse  = timing_q.v_sync_pulse;
   assign V_count_max   = timing_q.v_count_max;

endmodule

// File: tb/tb_vga_config.sv
// Self-checking bench for vga_config: directed vector table plus randomized run against a mode model.
module tb_vga_config;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        Valid = 1'b0;
   logic [1:0]  Addr = 2'b00;
   logic [1:0]  Data = 2'b00;
   logic        Load_config;
   logic [7:0]  H_front_porch, H_back_porch, V_front_porch, V_back_porch;
   logic [10:0] H_count_max, V_count_max;
   logic [7:0]  H_sync_pulse, V_sync_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected timing per mode index 0:640x480 1:800x600 2:1024x768
   int hfp  [3] = '{16, 40, 24};
   int hbp  [3] = '{48, 88, 160};
   int hs   [3] = '{96, 128, 136};
   int hmax [3] = '{799, 1055, 1343};
   int vfp  [3] = '{10, 1, 3};
   int vbp  [3] = '{33, 23, 29};
   int vs   [3] = '{2, 4, 6};
   int vmax [3] = '{524, 627, 805};

   typedef struct {
      bit       rst_n;
      bit       valid;
      bit [1:0] addr;
      bit [1:0] data;
      int       exp_mode;
      bit       exp_load;
   } vec_t;

   vec_t vecs[$];

   vga_config dut (
      .Clk           (Clk),
      .Rst           (Rst),
      .Valid         (Valid),
      .Addr          (Addr),
      .Data          (Data),
      .Load_config   (Load_config),
      .H_front_porch (H_front_porch),
      .H_back_porch  (H_back_porch),
      .V_front_porch (V_front_porch),
      .V_back_porch  (V_back_porch),
      .H_count_max   (H_count_max),
      .H_sync_pulse  (H_sync_pulse),
      .V_count_max   (V_count_max),
      .V_sync_pulse  (V_sync_pulse)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int step, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
      end
   endtask

   task automatic apply_and_check(input int step, input bit r, input bit v, input bit [1:0] a,
                                  input bit [1:0] d, input int m, input bit l);
      @(negedge Clk);
      Rst   = r;
      Valid = v;
      Addr  = a;
      Data  = d;
      @(posedge Clk);
      #2;
      chk("load_config",   step, int'(Load_config),   int'(l));
      chk("h_front_porch", step, int'(H_front_porch), hfp[m]);
      chk("h_back_porch",  step, int'(H_back_porch),  hbp[m]);
      chk("h_sync_pulse",  step, int'(H_sync_pulse),  hs[m]);
      chk("h_count_max",   step, int'(H_count_max),   hmax[m]);
      chk("v_front_porch", step, int'(V_front_porch), vfp[m]);
      chk("v_back_porch",  step, int'(V_back_porch),  vbp[m]);
      chk("v_sync_pulse",  step, int'(V_sync_pulse),  vs[m]);
      chk("v_count_max",   step, int'(V_count_max),   vmax[m]);
   endtask

   initial begin
      int  mode_m;
      bit  load_m;
      bit  r, v;
      bit [1:0] a, d;

      vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 0, 1'b0}); // reset
      vecs.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 0, 1'b0}); // release: no pulse
      vecs.push_back('{1'b1, 1'b1, 2'b10, 2'b00, 0, 1'b1}); // rewrite current mode
      vecs.push_back('{1'b1, 1'b0, 2'b10, 2'b00, 0, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 2'b10, 2'b10, 2, 1'b1}); // 1024x768
      vecs.push_back('{1'b1, 1'b0, 2'b10, 2'b00, 2, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 2'b10, 2'b00, 2, 1'b0}); // valid low
      vecs.push_back('{1'b1, 1'b1, 2'b00, 2'b00, 2, 1'b0}); // wrong address
      vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 0, 1'b0}); // mid-run reset
      vecs.push_back('{1'b1, 1'b1, 2'b10, 2'b01, 1, 1'b1}); // 800x600
      vecs.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 1, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 2'b10, 2'b11, 1, 1'b0}); // reserved code
      vecs.push_back('{1'b0, 1'b1, 2'b10, 2'b10, 0, 1'b0}); // reset beats write
      vecs.push_back('{1'b1, 1'b0, 2'b00, 2'b00, 0, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 2'b10, 2'b01, 1, 1'b1}); // valid held high
      vecs.push_back('{1'b1, 1'b1, 2'b10, 2'b01, 1, 1'b1});
      vecs.push_back('{1'b1, 1'b1, 2'b10, 2'b10, 2, 1'b1});
      vecs.push_back('{1'b1, 1'b1, 2'b01, 2'b01, 2, 1'b0});

      foreach (vecs[i])
         apply_and_check(i, vecs[i].rst_n, vecs[i].valid, vecs[i].addr, vecs[i].data,
                         vecs[i].exp_mode, vecs[i].exp_load);

      mode_m = 2;
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 15) != 0);
         v = ($urandom_range(0, 2) != 0);
         a = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'($urandom_range(0, 3));
         d = 2'($urandom_range(0, 3));
         if (!r) begin
            mode_m = 0;
            load_m = 1'b0;
         end else if (v && a == 2'd2 && d != 2'd3) begin
            mode_m = int'(d);
            load_m = 1'b1;
         end else begin
            load_m = 1'b0;
         end
         apply_and_check(1000 + i, r, v, a, d, mode_m, load_m);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
